iir_seq_ctrl: RTL and testbench

- Sequencer for a time-multiplexed (folded) IIR datapath: one multiply-accumulate unit steps through all taps for each sample, instead of a full parallel adder tree.
- Fetches each input sample from input memory and steps the MAC through the coefficient/history taps.
- Writes the result to output memory, shifts the x/y history registers, and raises Finish once input is exhausted.
- Sits between the memory interface (load/RAddr/DIn, WEN/WAddr) and the MAC/history datapath.

---
 rtl/iir_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_iir_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_seq_ctrl.sv
// Sequencer for a folded IIR: one MAC steps through NTAP taps per sample.
// Latency: 1 + MEM_LAT + NTAP + 2 cycles per sample, plus one per honoured hold cycle.
// Backpressure: hold stalls read issue and tap stepping; fixed-latency memory wait is never stalled.
module iir_seq_ctrl #(
   parameter int ADDR_W  = 20,
   parameter int NTAP    = 11,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              data_done,
   input  logic              hold,
   output logic              load,
   output logic [ADDR_W-1:0] RAddr,
   output logic              din_vld,
   output logic              acc_clr,
   output logic              acc_en,
   output logic [3:0]        tap_sel,
   output logic              WEN,
   output logic [ADDR_W-1:0] WAddr,
   output logic              hist_shift,
   output logic              busy,
   output logic              Finish
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, MAC, WRITE, SHIFT, DONE} state_t;

   localparam int                WAIT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);
   localparam logic [3:0]        TAP_LAST  = 4'(NTAP - 1);

   state_t              state;
   logic [ADDR_W-1:0]   n;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                done_flag;
   logic                end_seen;

   // End-of-input as seen by the SHIFT decision: the sticky flag or a request arriving this cycle.
   assign end_seen = done_flag | data_done;

   // Single FSM; every output is a register loaded with the value for the state being entered.
   // hold is sampled on the edge that would issue the read or step the tap, so a held edge
   // turns the following cycle into a stall cycle with load/acc_en low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         n          <= '0;
         wait_cnt   <= '0;
         done_flag  <= 1'b0;
         load       <= 1'b0;
         RAddr      <= '0;
         din_vld    <= 1'b0;
         acc_clr    <= 1'b0;
         acc_en     <= 1'b0;
         tap_sel    <= '0;
         WEN        <= 1'b0;
         WAddr      <= '0;
         hist_shift <= 1'b0;
         busy       <= 1'b0;
         Finish     <= 1'b0;
      end else begin
         load       <= 1'b0;
         din_vld    <= 1'b0;
         acc_clr    <= 1'b0;
         acc_en     <= 1'b0;
         WEN        <= 1'b0;
         hist_shift <= 1'b0;
         if (busy && data_done) done_flag <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  if (data_done) begin
                     state  <= DONE;
                     Finish <= 1'b1;
                  end else begin
                     state <= FETCH;
                     busy  <= 1'b1;
                     n     <= '0;
                     if (!hold) begin
                        load    <= 1'b1;
                        acc_clr <= 1'b1;
                        RAddr   <= '0;
                     end
                  end
               end
            end
            FETCH: begin
               // load high means the read went out this cycle; otherwise this was a stall cycle.
               if (load) begin
                  state    <= WAIT;
                  wait_cnt <= '0;
                  din_vld  <= (WAIT_LAST == '0);
               end else if (!hold) begin
                  load    <= 1'b1;
                  acc_clr <= 1'b1;
                  RAddr   <= n;
               end
            end
            WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state   <= MAC;
                  tap_sel <= '0;
                  acc_en  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
                  din_vld  <= ((wait_cnt + WAIT_W'(1)) == WAIT_LAST);
               end
            end
            MAC: begin
               // The visible tap has always been accumulated; a held edge just repeats it with acc_en low.
               if (!hold) begin
                  if (tap_sel == TAP_LAST) begin
                     state <= WRITE;
                     WEN   <= 1'b1;
                     WAddr <= n;
                  end else begin
                     tap_sel <= tap_sel + 4'd1;
                     acc_en  <= 1'b1;
                  end
               end
            end
            WRITE: begin
               state      <= SHIFT;
               hist_shift <= 1'b1;
            end
            SHIFT: begin
               // Saturate at the top address rather than wrapping back onto sample 0.
               if (end_seen || (n == '1)) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  Finish <= 1'b1;
               end else begin
                  state <= FETCH;
                  n     <= n + ADDR_W'(1);
                  if (!hold) begin
                     load    <= 1'b1;
                     acc_clr <= 1'b1;
                     RAddr   <= n + ADDR_W'(1);
                  end
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iir_seq_ctrl.sv
// Scoreboard bench for iir_seq_ctrl: expected load/WEN/Finish events are queued with cycle and address.
// Monitors pop and compare on every observed event; per-cycle directed checks cover stall and reset.
// Cycle 1 is the cycle after the edge that samples start.
module tb_iir_seq_ctrl;

   typedef struct {
      int kind;   // 0 load, 1 WEN, 2 Finish rise
      int cyc;
      int addr;
   } ev_t;

   logic        clk, rst, start, data_done, hold, start4;
   logic        load, din_vld, acc_clr, acc_en, WEN, hist_shift, busy, Finish;
   logic [19:0] RAddr, WAddr;
   logic [3:0]  tap_sel;
   logic        load4, din_vld4, acc_clr4, acc_en4, WEN4, hist_shift4, busy4, Finish4;
   logic [3:0]  RAddr4, WAddr4, tap_sel4;
   logic        data_done4, hold4;

   int tests = 0;
   int fails = 0;
   int count = 0;
   int t0 = 0;
   int t0_4 = 0;
   int nacc;
   ev_t q[$];
   ev_t q4[$];

   iir_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .data_done(data_done), .hold(hold),
      .load(load), .RAddr(RAddr), .din_vld(din_vld), .acc_clr(acc_clr), .acc_en(acc_en),
      .tap_sel(tap_sel), .WEN(WEN), .WAddr(WAddr), .hist_shift(hist_shift),
      .busy(busy), .Finish(Finish)
   );

   iir_seq_ctrl #(.ADDR_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .data_done(data_done4), .hold(hold4),
      .load(load4), .RAddr(RAddr4), .din_vld(din_vld4), .acc_clr(acc_clr4), .acc_en(acc_en4),
      .tap_sel(tap_sel4), .WEN(WEN4), .WAddr(WAddr4), .hist_shift(hist_shift4),
      .busy(busy4), .Finish(Finish4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) count <= count + 1;

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_ev(input string nm, input bit have, input ev_t e,
                         input int kind, input int cyc, input int addr);
      tests++;
      if (!have || e.kind != kind || e.cyc != cyc || e.addr != addr) begin
         fails++;
         $display("FAIL %s event: got kind=%0d cyc=%0d addr=%0d, want kind=%0d cyc=%0d addr=%0d (queued=%0d)",
                  nm, kind, cyc, addr, e.kind, e.cyc, e.addr, have);
      end
   endtask

   function automatic ev_t mk(input int kind, input int cyc, input int addr);
      ev_t e;
      e.kind = kind; e.cyc = cyc; e.addr = addr;
      return e;
   endfunction

   // Monitor for the default-width instance.
   always @(negedge clk) begin
      ev_t e;
      bit  have;
      bit  fin_prev;
      e = mk(-1, -1, -1);
      if (load) begin
         have = (q.size() > 0); if (have) e = q.pop_front();
         chk_ev("load", have, e, 0, count - t0, int'(RAddr));
      end
      if (WEN) begin
         have = (q.size() > 0); if (have) e = q.pop_front();
         chk_ev("wen", have, e, 1, count - t0, int'(WAddr));
      end
      if (Finish && !fin_prev) begin
         have = (q.size() > 0); if (have) e = q.pop_front();
         chk_ev("finish", have, e, 2, count - t0, 0);
      end
      fin_prev = Finish;
   end

   // Monitor for the 4-bit address instance.
   always @(negedge clk) begin
      ev_t e;
      bit  have;
      bit  fin_prev;
      e = mk(-1, -1, -1);
      if (load4) begin
         have = (q4.size() > 0); if (have) e = q4.pop_front();
         chk_ev("load4", have, e, 0, count - t0_4, int'(RAddr4));
      end
      if (WEN4) begin
         have = (q4.size() > 0); if (have) e = q4.pop_front();
         chk_ev("wen4", have, e, 1, count - t0_4, int'(WAddr4));
      end
      if (Finish4 && !fin_prev) begin
         have = (q4.size() > 0); if (have) e = q4.pop_front();
         chk_ev("finish4", have, e, 2, count - t0_4, 0);
      end
      fin_prev = Finish4;
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; data_done = 1'b0; hold = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drives start during cycle 0; cycle index is count - t0 from here on.
   task automatic kick();
      @(negedge clk);
      t0 = count;
      start = 1'b1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; data_done = 1'b0; hold = 1'b0;
      start4 = 1'b0; data_done4 = 1'b0; hold4 = 1'b0;

      // Reset values and three samples ending with data_done in the third MAC phase
      do_reset();
      check("rst_load", load, 0);
      check("rst_wen", WEN, 0);
      check("rst_raddr", int'(RAddr), 0);
      check("rst_waddr", int'(WAddr), 0);
      check("rst_tap", int'(tap_sel), 0);
      check("rst_busy", busy, 0);
      check("rst_finish", Finish, 0);
      for (int k = 0; k < 3; k++) begin
         q.push_back(mk(0, 1 + 15 * k, k));
         q.push_back(mk(1, 14 + 15 * k, k));
      end
      q.push_back(mk(2, 46, 0));
      kick();
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start = 1'b0;
         data_done = (c == 35);
         if (c == 1) begin check("a_busy1", busy, 1); check("a_accclr1", acc_clr, 1); end
         if (c == 2) check("a_dinvld2", din_vld, 1);
         if (c == 3) check("a_tap0_en", acc_en, 1);
         if (c == 15) check("a_shift15", hist_shift, 1);
         if (c == 45) check("a_finish45", Finish, 0);
      end
      check("a_queue_empty", q.size(), 0);
      check("a_finish_end", Finish, 1);
      check("a_busy_end", busy, 0);

      // One sample with hold across three edges while tap 5 is shown
      do_reset();
      q.push_back(mk(0, 1, 0));
      q.push_back(mk(1, 17, 0));
      q.push_back(mk(2, 19, 0));
      nacc = 0;
      kick();
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         start = 1'b0;
         data_done = (c == 5);
         if (acc_en) nacc++;
         if (c == 8) check("b_tap_pre", int'(tap_sel), 5);
         if (c >= 9 && c <= 11) begin
            check("b_tap_frozen", int'(tap_sel), 5);
            check("b_acc_off", acc_en, 0);
         end
         if (c == 12) check("b_tap_resume", int'(tap_sel), 6);
         hold = (c >= 8 && c <= 10);
      end
      check("b_acc_pulses", nacc, 11);
      check("b_queue_empty", q.size(), 0);

      // hold on the edges entering FETCH delays the read by two cycles
      do_reset();
      q.push_back(mk(0, 3, 0));
      q.push_back(mk(1, 16, 0));
      q.push_back(mk(2, 18, 0));
      hold = 1'b1;
      kick();
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         start = 1'b0;
         hold = (c == 1);
         data_done = (c == 5);
         if (c == 1 || c == 2) check("c_no_accclr", acc_clr, 0);
         if (c == 3) check("c_accclr_with_load", acc_clr, 1);
      end
      check("c_queue_empty", q.size(), 0);

      // start with data_done already high goes straight to DONE
      do_reset();
      q.push_back(mk(2, 1, 0));
      data_done = 1'b1;
      kick();
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         data_done = 1'b0;
         check("d_busy_never", busy, 0);
      end
      check("d_finish", Finish, 1);
      check("d_queue_empty", q.size(), 0);

      // Reset during tap 7 of the fourth sample, then a fresh start from address 0
      do_reset();
      for (int k = 0; k < 4; k++) q.push_back(mk(0, 1 + 15 * k, k));
      for (int k = 0; k < 3; k++) q.push_back(mk(1, 14 + 15 * k, k));
      q.sort() with (item.cyc);
      kick();
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start = 1'b0;
         rst = 1'b0;
         if (c == 55) begin
            check("e_tap7", int'(tap_sel), 7);
            rst = 1'b1;
         end
         if (c == 56) begin
            check("e_rst_tap", int'(tap_sel), 0);
            check("e_rst_accen", acc_en, 0);
            check("e_rst_raddr", int'(RAddr), 0);
            check("e_rst_waddr", int'(WAddr), 0);
            check("e_rst_busy", busy, 0);
         end
      end
      check("e_queue_empty", q.size(), 0);
      q.push_back(mk(0, 1, 0));
      q.push_back(mk(1, 14, 0));
      q.push_back(mk(2, 16, 0));
      kick();
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         data_done = (c == 5);
      end
      check("e_restart_empty", q.size(), 0);

      // 4-bit address instance runs all 16 samples and stops without wrapping
      for (int k = 0; k < 16; k++) begin
         q4.push_back(mk(0, 1 + 15 * k, k));
         q4.push_back(mk(1, 14 + 15 * k, k));
      end
      q4.push_back(mk(2, 241, 0));
      @(negedge clk);
      t0_4 = count;
      start4 = 1'b1;
      for (int c = 1; c <= 260; c++) begin
         @(negedge clk);
         start4 = 1'b0;
      end
      check("f_queue_empty", q4.size(), 0);
      check("f_finish", Finish4, 1);
      check("f_raddr_last", int'(RAddr4), 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
